// File: rtl/l4_route_seq.sv
// l4_route_seq: host-side command sequencer for the 16x16 L4 router array.
// Runs one route request: clear, mark source/target, then expand the wavefront
// until the target is hit and trace back to the source.
// Optional feature: define L4_SEQ_TIMEOUT_EN to fail a route once step_count
// reaches MAX_STEPS without a target hit.

module l4_route_seq #(
    parameter int NRBITS    = 4,
    parameter int NCBITS    = 4,
    parameter int STAT_LAT  = 2,
    parameter int MAX_STEPS = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NRBITS-1:0] src_row,
    input  logic [NCBITS-1:0] src_col,
    input  logic [NRBITS-1:0] tgt_row,
    input  logic [NCBITS-1:0] tgt_col,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic [7:0]        step_count,
    output logic [2:0]        row_range_sel,
    output logic [NRBITS-1:0] row_l_v,
    output logic [NRBITS-1:0] row_u_v,
    output logic [2:0]        col_range_sel,
    output logic [NCBITS-1:0] col_l_v,
    output logic [NCBITS-1:0] col_u_v,
    output logic [1:0]        cell_cmd,
    output logic [3:0]        status_in,
    output logic              ret2ue,
    output logic              extend,
    input  logic [3:0]        array_status
);

    localparam logic [2:0] SEL_SINGLE = 3'b001;
    localparam logic [2:0] SEL_ALL    = 3'b011;
    localparam logic [1:0] CMD_WRITE  = 2'b01;
    localparam logic [1:0] CMD_EXPAND = 2'b10;
    localparam logic [1:0] CMD_TRACE  = 2'b11;

    localparam int            CW         = (STAT_LAT > 1) ? $clog2(STAT_LAT) : 1;
    localparam logic [CW-1:0] WAIT_LOAD  = CW'(STAT_LAT - 1);
    localparam logic [7:0]    STEP_LIMIT = 8'(MAX_STEPS);

`ifdef L4_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_SET_SRC, S_SET_TGT, S_EXPAND, S_TRACE,
        S_WAIT, S_CHECK_EXP, S_CHECK_TRC, S_DONE, S_FAIL
    } state_t;

    state_t            state;
    state_t            state_next;
    state_t            wait_ret;
    logic [CW-1:0]     wait_cnt;
    logic [NRBITS-1:0] src_r;
    logic [NCBITS-1:0] src_c;
    logic [NRBITS-1:0] tgt_r;
    logic [NCBITS-1:0] tgt_c;
    logic [8:0]        trace_cnt;
    logic [3:0]        status_q;
    logic              same_cell;
    logic              trace_over;
    logic              at_limit;

    assign same_cell  = (src_r == tgt_r) && (src_c == tgt_c);
    assign trace_over = (trace_cnt >= ({1'b0, step_count} + 9'd1));
    assign at_limit   = TIMEOUT_EN && (step_count == STEP_LIMIT);

    // State register; reset aborts any route in flight without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Request latch, wait counter, step/trace counters and result flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_ret   <= S_IDLE;
            wait_cnt   <= '0;
            src_r      <= '0;
            src_c      <= '0;
            tgt_r      <= '0;
            tgt_c      <= '0;
            trace_cnt  <= '0;
            status_q   <= '0;
            step_count <= '0;
            success    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_r      <= src_row;
                        src_c      <= src_col;
                        tgt_r      <= tgt_row;
                        tgt_c      <= tgt_col;
                        step_count <= '0;
                        trace_cnt  <= '0;
                        success    <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    wait_cnt <= WAIT_LOAD;
                    wait_ret <= S_SET_SRC;
                end
                S_SET_SRC: begin
                    wait_cnt <= WAIT_LOAD;
                    wait_ret <= same_cell ? S_DONE : S_SET_TGT;
                end
                S_SET_TGT: begin
                    wait_cnt <= WAIT_LOAD;
                    wait_ret <= S_EXPAND;
                end
                S_EXPAND: begin
                    wait_cnt <= WAIT_LOAD;
                    wait_ret <= S_CHECK_EXP;
                    if (step_count != 8'hFF) step_count <= step_count + 8'd1;
                end
                S_TRACE: begin
                    wait_cnt  <= WAIT_LOAD;
                    wait_ret  <= S_CHECK_TRC;
                    trace_cnt <= trace_cnt + 9'd1;
                end
                S_WAIT: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                    else                status_q <= array_status;
                end
                default: ;
            endcase
            if (state_next == S_DONE) success <= 1'b1;
            else if (state_next == S_FAIL) success <= 1'b0;
        end
    end

    // Next-state decisions, including status evaluation after each wait.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (start) state_next = S_CLEAR;
            S_CLEAR, S_SET_SRC, S_SET_TGT, S_EXPAND, S_TRACE:
                         state_next = S_WAIT;
            S_WAIT:      if (wait_cnt == '0) state_next = wait_ret;
            S_CHECK_EXP: begin
                if (status_q[3])       state_next = S_FAIL;
                else if (status_q[1])  state_next = S_TRACE;
                else if (!status_q[0]) state_next = S_FAIL;
                else if (at_limit)     state_next = S_FAIL;
                else                   state_next = S_EXPAND;
            end
            S_CHECK_TRC: begin
                if (status_q[2])      state_next = S_DONE;
                else if (status_q[3]) state_next = S_FAIL;
                else if (trace_over)  state_next = S_FAIL;
                else                  state_next = S_TRACE;
            end
            S_DONE, S_FAIL: state_next = S_IDLE;
            default:        state_next = S_IDLE;
        endcase
    end

    // Array command outputs decoded from the current state; NOP everywhere else.
    always_comb begin
        busy          = (state != S_IDLE);
        done          = (state == S_DONE) || (state == S_FAIL);
        row_range_sel = '0;
        row_l_v       = '0;
        row_u_v       = '0;
        col_range_sel = '0;
        col_l_v       = '0;
        col_u_v       = '0;
        cell_cmd      = '0;
        status_in     = '0;
        ret2ue        = 1'b0;
        extend        = 1'b0;
        case (state)
            S_CLEAR, S_EXPAND, S_TRACE: begin
                row_range_sel = SEL_ALL;
                row_u_v       = '1;
                col_range_sel = SEL_ALL;
                col_u_v       = '1;
            end
            S_SET_SRC: begin
                row_range_sel = SEL_SINGLE;
                row_l_v       = src_r;
                row_u_v       = src_r;
                col_range_sel = SEL_SINGLE;
                col_l_v       = src_c;
                col_u_v       = src_c;
            end
            S_SET_TGT: begin
                row_range_sel = SEL_SINGLE;
                row_l_v       = tgt_r;
                row_u_v       = tgt_r;
                col_range_sel = SEL_SINGLE;
                col_l_v       = tgt_c;
                col_u_v       = tgt_c;
            end
            default: ;
        endcase
        case (state)
            S_CLEAR: begin
                cell_cmd = CMD_WRITE;
                ret2ue   = 1'b1;
            end
            S_SET_SRC: begin
                cell_cmd  = CMD_WRITE;
                status_in = 4'b0001;
            end
            S_SET_TGT: begin
                cell_cmd  = CMD_WRITE;
                status_in = 4'b0010;
            end
            S_EXPAND: begin
                cell_cmd = CMD_EXPAND;
                extend   = 1'b1;
            end
            S_TRACE: cell_cmd = CMD_TRACE;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l4_route_seq.sv
// tb_l4_route_seq: randomized and directed route requests against l4_route_seq,
// with a scenario-driven router array model and a rule-level outcome predictor.

module tb_l4_route_seq;

    localparam int L     = 2;
    localparam int NEVER = 100000;
`ifdef L4_SEQ_TIMEOUT_EN
    localparam int MAXS  = 3;
    localparam bit TO_EN = 1'b1;
`else
    localparam int MAXS  = 31;
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] src_row, src_col, tgt_row, tgt_col;
    logic       busy, done, success;
    logic [7:0] step_count;
    logic [2:0] row_range_sel, col_range_sel;
    logic [3:0] row_l_v, row_u_v, col_l_v, col_u_v;
    logic [1:0] cell_cmd;
    logic [3:0] status_in;
    logic       ret2ue, extend;
    logic [3:0] array_status;

    l4_route_seq #(
        .NRBITS(4), .NCBITS(4), .STAT_LAT(L), .MAX_STEPS(MAXS)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_row(src_row), .src_col(src_col), .tgt_row(tgt_row), .tgt_col(tgt_col),
        .busy(busy), .done(done), .success(success), .step_count(step_count),
        .row_range_sel(row_range_sel), .row_l_v(row_l_v), .row_u_v(row_u_v),
        .col_range_sel(col_range_sel), .col_l_v(col_l_v), .col_u_v(col_u_v),
        .cell_cmd(cell_cmd), .status_in(status_in), .ret2ue(ret2ue), .extend(extend),
        .array_status(array_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // scenario for the array model: hit/wall/error expansion index, trace length, trace error index
    int sc_h, sc_w, sc_e, sc_d, sc_te;
    int exp_seen, trc_seen;
    int pipe [0:L];
    logic [3:0] m_sr, m_sc, m_tr, m_tc;
    int n_exp, n_trc, n_clr, n_src, n_tgt, n_done, bad_fmt, bad_once;
    logic [1:0] prev_cmd;

    task automatic check_output(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit single_ok(input logic [3:0] r, input logic [3:0] c);
        return row_range_sel == 3'b001 && col_range_sel == 3'b001 &&
               row_l_v == r && row_u_v == r && col_l_v == c && col_u_v == c;
    endfunction

    function automatic bit all_ok();
        return row_range_sel == 3'b011 && col_range_sel == 3'b011;
    endfunction

    function automatic int ctrl_word();
        return int'({busy, done, success, step_count, row_range_sel, col_range_sel,
                     cell_cmd, status_in, ret2ue, extend});
    endfunction

    function automatic int bounds_word();
        return int'({row_l_v, row_u_v, col_l_v, col_u_v});
    endfunction

    // One clock: observe the command of this cycle, answer it through an
    // L-deep status pipeline like the real array.
    task automatic tick();
        int resp;
        @(posedge clk);
        #1;
        resp = 0;
        if (done) n_done++;
        if (cell_cmd != 2'b00 && prev_cmd != 2'b00) bad_once++;
        prev_cmd = cell_cmd;
        case (cell_cmd)
            2'b00: if (row_range_sel != 0 || col_range_sel != 0 || ret2ue || extend ||
                       status_in != 0) bad_fmt++;
            2'b01: begin
                case (status_in)
                    4'b0000: begin
                        n_clr++;
                        if (!(all_ok() && ret2ue && !extend)) bad_fmt++;
                    end
                    4'b0001: begin
                        n_src++;
                        if (!(single_ok(m_sr, m_sc) && !ret2ue && !extend)) bad_fmt++;
                    end
                    4'b0010: begin
                        n_tgt++;
                        if (!(single_ok(m_tr, m_tc) && !ret2ue && !extend)) bad_fmt++;
                    end
                    default: bad_fmt++;
                endcase
            end
            2'b10: begin
                n_exp++;
                exp_seen++;
                if (!(all_ok() && extend && !ret2ue)) bad_fmt++;
                resp = (exp_seen == sc_e ? 8 : 0) + (exp_seen == sc_h ? 2 : 0) +
                       (exp_seen < sc_w ? 1 : 0);
            end
            default: begin
                n_trc++;
                trc_seen++;
                if (!(all_ok() && !extend && !ret2ue)) bad_fmt++;
                resp = (trc_seen == sc_te ? 8 : 0) + (trc_seen == sc_d ? 4 : 0);
            end
        endcase
        for (int i = L; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = resp;
        array_status = 4'(pipe[L]);
    endtask

    // Route outcome straight from the sequencing rules.
    task automatic predict(input logic [3:0] sr, sc, tr, tc, input int h, w, e, d, te,
                           output int p_succ, p_step, p_nexp, p_ntrc);
        int  k;
        int  step;
        bit  tracing;
        p_succ = 0; p_step = 0; p_nexp = 0; p_ntrc = 0;
        if (sr == tr && sc == tc) begin
            p_succ = 1;
            return;
        end
        tracing = 1'b0;
        k = 0;
        step = 0;
        while (k < 5000) begin
            k++;
            step   = (k > 255) ? 255 : k;
            p_nexp = k;
            p_step = step;
            if (k == e) break;
            if (k == h) begin
                tracing = 1'b1;
                break;
            end
            if (k >= w) break;
            if (TO_EN && step == MAXS) break;
        end
        if (!tracing) return;
        for (int i = 1; i <= 5000; i++) begin
            p_ntrc = i;
            if (i == d) begin
                p_succ = 1;
                break;
            end
            if (i == te) break;
            if (i >= step + 1) break;
        end
    endtask

    task automatic clear_counts();
        exp_seen = 0; trc_seen = 0;
        n_exp = 0; n_trc = 0; n_clr = 0; n_src = 0; n_tgt = 0;
        n_done = 0; bad_fmt = 0; bad_once = 0;
    endtask

    task automatic apply_stimulus(input string name, input logic [3:0] sr, sc, tr, tc,
                                  input int h, w, e, d, te, input bit check_lat,
                                  input int glitch_at);
        int cyc;
        int p_succ, p_step, p_nexp, p_ntrc;
        int got_succ, got_step;
        predict(sr, sc, tr, tc, h, w, e, d, te, p_succ, p_step, p_nexp, p_ntrc);
        sc_h = h; sc_w = w; sc_e = e; sc_d = d; sc_te = te;
        m_sr = sr; m_sc = sc; m_tr = tr; m_tc = tc;
        clear_counts();
        src_row = sr; src_col = sc; tgt_row = tr; tgt_col = tc;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        check_output({name, ":busy"}, int'(busy), 1);
        while (n_done == 0 && cyc < 6000) begin
            if (cyc == glitch_at) begin
                start = 1'b1;
                src_row = ~sr; src_col = ~sc; tgt_row = ~tr; tgt_col = ~tc;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        if (n_done == 0) begin
            check_output({name, ":done_seen"}, 0, 1);
            return;
        end
        got_succ = int'(success);
        got_step = int'(step_count);
        if (check_lat) check_output({name, ":latency"}, cyc, 3 + 2 * L);
        check_output({name, ":success"}, got_succ, p_succ);
        check_output({name, ":step_count"}, got_step, p_step);
        check_output({name, ":expands"}, n_exp, p_nexp);
        check_output({name, ":traces"}, n_trc, p_ntrc);
        check_output({name, ":writes"}, n_clr * 100 + n_src * 10 + n_tgt,
                     (sr == tr && sc == tc) ? 110 : 111);
        check_output({name, ":cmd_format"}, bad_fmt, 0);
        check_output({name, ":cmd_one_cycle"}, bad_once, 0);
        repeat (3) tick();
        check_output({name, ":idle_after"}, int'({busy, done}), 0);
        check_output({name, ":done_pulses"}, n_done, 1);
        check_output({name, ":step_held"}, int'(step_count), p_step);
    endtask

    task automatic test_reset_mid();
        int cyc;
        sc_h = 10; sc_w = NEVER; sc_e = NEVER; sc_d = 10; sc_te = NEVER;
        m_sr = 4'd0; m_sc = 4'd0; m_tr = 4'd3; m_tc = 4'd7;
        clear_counts();
        src_row = m_sr; src_col = m_sc; tgt_row = m_tr; tgt_col = m_tc;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cell_cmd != 2'b10 && cyc < 200) begin
            tick();
            cyc++;
        end
        check_output("rst_mid:reached_expand", int'(cell_cmd == 2'b10), 1);
        #2 reset = 1'b1;
        #1;
        check_output("rst_mid:ctrl", ctrl_word(), 0);
        check_output("rst_mid:bounds", bounds_word(), 0);
        n_done = 0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (6) tick();
        check_output("rst_mid:no_done", n_done, 0);
        check_output("rst_mid:ctrl_after", ctrl_word(), 0);
    endtask

    initial begin
        logic [3:0] sr, sc, tr, tc;
        int h, w, e, d, te, dr, dc;
        reset = 1'b1;
        start = 1'b0;
        src_row = '0; src_col = '0; tgt_row = '0; tgt_col = '0;
        array_status = '0;
        prev_cmd = '0;
        for (int i = 0; i <= L; i++) pipe[i] = 0;
        clear_counts();
        repeat (2) tick();
        check_output("reset:ctrl", ctrl_word(), 0);
        check_output("reset:bounds", bounds_word(), 0);
        reset = 1'b0;
        tick();

        apply_stimulus("open_2_3_to_2_7", 4'd2, 4'd3, 4'd2, 4'd7, 4, NEVER, NEVER, 4, NEVER, 1'b0, -1);
        apply_stimulus("same_cell_5_5", 4'd5, 4'd5, 4'd5, 4'd5, 0, NEVER, NEVER, 0, NEVER, 1'b1, -1);
        apply_stimulus("walled_off", 4'd1, 4'd1, 4'd8, 4'd14, 20, 6, NEVER, 20, NEVER, 1'b0, -1);
        apply_stimulus("err_beats_hit", 4'd0, 4'd0, 4'd1, 4'd2, 3, NEVER, 3, 3, NEVER, 1'b0, -1);
        apply_stimulus("start_while_busy", 4'd4, 4'd4, 4'd6, 4'd9, 7, NEVER, NEVER, 7, NEVER, 1'b0, 2);
        apply_stimulus("trace_error", 4'd9, 4'd2, 4'd3, 4'd3, 7, NEVER, NEVER, 7, 4, 1'b0, -1);
        apply_stimulus("trace_at_bound", 4'd0, 4'd15, 4'd2, 4'd15, 2, NEVER, NEVER, 3, NEVER, 1'b0, -1);
        apply_stimulus("trace_overrun", 4'd0, 4'd15, 4'd2, 4'd15, 2, NEVER, NEVER, 4, NEVER, 1'b0, -1);
        apply_stimulus("step_saturate", 4'd0, 4'd0, 4'd15, 4'd15, 300, NEVER, NEVER, 256, NEVER, 1'b0, -1);

        for (int n = 0; n < 10; n++) begin
            sr = 4'($urandom_range(0, 15));
            sc = 4'($urandom_range(0, 15));
            tr = 4'($urandom_range(0, 15));
            tc = 4'($urandom_range(0, 15));
            dr = int'(sr) - int'(tr);
            dc = int'(sc) - int'(tc);
            if (dr < 0) dr = -dr;
            if (dc < 0) dc = -dc;
            h  = dr + dc;
            w  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, h + 2)) : NEVER;
            e  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, h + 2)) : NEVER;
            case ($urandom_range(0, 3))
                0:       d = h + 2;
                1:       d = int'($urandom_range(1, h + 1));
                default: d = h;
            endcase
            te = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, h + 1)) : NEVER;
            if (te == d) te = NEVER;
            apply_stimulus($sformatf("rand%0d", n), sr, sc, tr, tc, h, w, e, d, te, 1'b0, -1);
        end

        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
